// File: rtl/reflet_ram8_word_arbiter_pkg.sv
// Shared definitions for the two-port word arbiter in front of reflet_ram8:
// controller state encoding and word/byte sizing helpers.
package reflet_ram8_word_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_CAPT = 3'd2,
      WR      = 3'd3,
      ACK     = 3'd4
   } ctrl_state_t;

   localparam int STATE_W = 3;

   function automatic int word_bytes(input int word_size);
      return word_size / 8;
   endfunction

   // Width of the byte index; kept at least one bit so a one-byte word still works.
   function automatic int byte_sel_width(input int wb);
      return (wb > 1) ? $clog2(wb) : 1;
   endfunction

endpackage

// File: rtl/reflet_ram8_word_arbiter_rr_arbiter2.sv
// Two-request round-robin grant. The last-grant register is updated when the
// owning controller strobes grant_done at the end of a served access.
module reflet_rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       grant_done,
   input  logic       done_port,
   output logic       grant_valid,
   output logic       grant_port
);

   logic last_port;

   // Reset to "port 1 granted last" so port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset)
         last_port <= 1'b1;
      else if (grant_done)
         last_port <= done_port;
   end

   always_comb begin
      grant_valid = |req;
      grant_port  = (req == 2'b11) ? ~last_port : req[1];
   end

endmodule

// File: rtl/reflet_ram8_word_arbiter.sv
// Shares one byte-wide synchronous RAM between two word requesters; each granted
// word access is split into little-endian byte accesses on the RAM side.
module reflet_ram8_word_arbiter
   import reflet_ram8_word_arbiter_pkg::*;
#(
   parameter int wordSize = 16,
   parameter int addrSize = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0,
   input  logic                we0,
   input  logic [addrSize-1:0] addr0,
   input  logic [wordSize-1:0] wdata0,
   output logic                ack0,
   input  logic                req1,
   input  logic                we1,
   input  logic [addrSize-1:0] addr1,
   input  logic [wordSize-1:0] wdata1,
   output logic                ack1,
   output logic [wordSize-1:0] rdata,
   output logic                ram_enable,
   output logic [addrSize-1:0] ram_addr,
   output logic [7:0]          ram_data_in,
   output logic                ram_write_en,
   input  logic [7:0]          ram_data_out,
   output logic [STATE_W-1:0]  dbg_state
);

   localparam int WB = word_bytes(wordSize);
   localparam int KW = byte_sel_width(WB);

   // Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
   // them until ackN pulses for one cycle; it drops reqN at the edge ending that
   // cycle. Any req seen while the controller is in IDLE starts a new access.

   ctrl_state_t         state;
   logic [KW-1:0]       k;
   logic [KW-1:0]       next_k;
   logic                last_byte;
   logic [addrSize-1:0] lat_addr;
   logic [wordSize-1:0] lat_wdata;
   logic                gnt_port;

   logic                grant_valid;
   logic                grant_port;
   logic                grant_done;

   logic                sel_we;
   logic [addrSize-1:0] sel_addr;
   logic [wordSize-1:0] sel_wdata;

   reflet_rr_arbiter2 u_rr (
      .clk         (clk),
      .reset       (reset),
      .req         ({req1, req0}),
      .grant_done  (grant_done),
      .done_port   (gnt_port),
      .grant_valid (grant_valid),
      .grant_port  (grant_port)
   );

   assign grant_done = (state == ACK);
   assign next_k     = k + 1'b1;
   assign last_byte  = (k == KW'(WB - 1));
   assign dbg_state  = state;

   always_comb begin
      sel_we    = grant_port ? we1    : we0;
      sel_addr  = grant_port ? addr1  : addr0;
      sel_wdata = grant_port ? wdata1 : wdata0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         ram_enable   <= 1'b0;
         ram_write_en <= 1'b0;
         rdata        <= '0;
         ram_addr     <= '0;
         ram_data_in  <= '0;
         k            <= '0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         gnt_port     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  gnt_port     <= grant_port;
                  lat_addr     <= sel_addr;
                  lat_wdata    <= sel_wdata;
                  k            <= '0;
                  ram_enable   <= 1'b1;
                  ram_addr     <= sel_addr;
                  ram_write_en <= sel_we;
                  if (sel_we) begin
                     ram_data_in <= sel_wdata[7:0];
                     state       <= WR;
                  end else begin
                     state       <= RD_ADDR;
                  end
               end
            end

            RD_ADDR: begin
               state <= RD_CAPT;
            end

            // The RAM only drives data while enable/addr are still applied, so
            // the address is held through the capture cycle.
            RD_CAPT: begin
               rdata[8*k +: 8] <= ram_data_out;
               if (last_byte) begin
                  ram_enable <= 1'b0;
                  ack0       <= ~gnt_port;
                  ack1       <= gnt_port;
                  state      <= ACK;
               end else begin
                  k        <= next_k;
                  ram_addr <= lat_addr + addrSize'(next_k);
                  state    <= RD_ADDR;
               end
            end

            WR: begin
               if (last_byte) begin
                  ram_enable   <= 1'b0;
                  ram_write_en <= 1'b0;
                  ack0         <= ~gnt_port;
                  ack1         <= gnt_port;
                  state        <= ACK;
               end else begin
                  k           <= next_k;
                  ram_addr    <= lat_addr + addrSize'(next_k);
                  ram_data_in <= lat_wdata[8*next_k +: 8];
               end
            end

            ACK: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               ram_enable   <= 1'b0;
               ram_write_en <= 1'b0;
               ack0         <= 1'b0;
               ack1         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reflet_ram8_word_arbiter.sv
// Bench for reflet_ram8_word_arbiter: behavioural byte RAM, transaction-level
// reference model with a per-cycle expectation table, directed and random traffic.
module tb_reflet_ram8_word_arbiter;

   localparam int WS = 16;
   localparam int AS = 7;
   localparam int WB = WS / 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_v   [2];
   logic          we_v    [2];
   logic [AS-1:0] addr_v  [2];
   logic [WS-1:0] wdata_v [2];
   logic          ack0, ack1;
   logic [WS-1:0] rdata;
   logic          ram_enable, ram_write_en;
   logic [AS-1:0] ram_addr;
   logic [7:0]    ram_data_in, ram_data_out;
   logic [2:0]    dbg_state;

   reflet_ram8_word_arbiter #(.wordSize(WS), .addrSize(AS)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0         (req_v[0]),
      .we0          (we_v[0]),
      .addr0        (addr_v[0]),
      .wdata0       (wdata_v[0]),
      .ack0         (ack0),
      .req1         (req_v[1]),
      .we1          (we_v[1]),
      .addr1        (addr_v[1]),
      .wdata1       (wdata_v[1]),
      .ack1         (ack1),
      .rdata        (rdata),
      .ram_enable   (ram_enable),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_write_en (ram_write_en),
      .ram_data_out (ram_data_out),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- byte RAM stand-in (registered read, gated output) ----------------
   logic [7:0] ram_mem [0:127];
   logic [7:0] ram_q;
   int         ram_size = 128;

   always @(posedge clk) begin
      if (ram_enable && (int'(ram_addr) < ram_size)) begin
         ram_q <= ram_mem[ram_addr];
         if (ram_write_en) ram_mem[ram_addr] <= ram_data_in;
      end else begin
         ram_q <= 8'h00;
      end
   end
   assign ram_data_out = (ram_enable && (int'(ram_addr) < ram_size)) ? ram_q : 8'h00;

   // ---------------- scoreboard bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          en;
      bit          wr;
      logic [6:0]  addr;
      logic [7:0]  wd;
      int          ack;
      bit          rd;
      logic [15:0] rword;
   } cyc_exp_t;

   cyc_exp_t   exp_tab [int];
   logic [7:0] ref_mem [0:127];
   bit         model_on = 0;
   int         rr_last  = 1;
   int         busy_end = 0;
   int         m_cur;

   function automatic cyc_exp_t blank();
      cyc_exp_t e;
      e.en = 0; e.wr = 0; e.addr = '0; e.wd = '0; e.ack = -1; e.rd = 0; e.rword = '0;
      return e;
   endfunction

   function automatic void purge_after(input int c);
      int keys[$];
      foreach (exp_tab[key]) if (key > c) keys.push_back(key);
      foreach (keys[i]) exp_tab.delete(keys[i]);
   endfunction

   // A word access granted in cycle g occupies cycles g+1.. with byte traffic
   // and acks WB+1 (write) or 2*WB+1 (read) cycles after g.
   task automatic schedule(input int g, input int p);
      cyc_exp_t    e;
      logic [6:0]  ba;
      logic [15:0] word;
      logic [15:0] d;
      d = wdata_v[p];
      if (we_v[p]) begin
         for (int i = 0; i < WB; i++) begin
            e = blank(); e.en = 1; e.wr = 1;
            ba = addr_v[p] + 7'(i);
            e.addr = ba;
            e.wd = 8'((d >> (8 * i)) & 16'h00ff);
            exp_tab[g + 1 + i] = e;
         end
         e = blank(); e.ack = p;
         exp_tab[g + WB + 1] = e;
         busy_end = g + WB + 1;
      end else begin
         word = '0;
         for (int i = 0; i < WB; i++) begin
            ba = addr_v[p] + 7'(i);
            if (int'(ba) < ram_size) word = word | (16'(ref_mem[ba]) << (8 * i));
            e = blank(); e.en = 1; e.addr = ba;
            exp_tab[g + 1 + 2 * i] = e;
            exp_tab[g + 2 + 2 * i] = e;
         end
         e = blank(); e.ack = p; e.rd = 1; e.rword = word;
         exp_tab[g + 2 * WB + 1] = e;
         busy_end = g + 2 * WB + 1;
      end
   endtask

   always @(posedge clk) begin
      m_cur = cyc;
      if (exp_tab.exists(m_cur) && exp_tab[m_cur].wr && (int'(exp_tab[m_cur].addr) < ram_size))
         ref_mem[exp_tab[m_cur].addr] = exp_tab[m_cur].wd;
      if (!reset) begin
         model_on = 1;
         rr_last  = 1;
         busy_end = m_cur;
         purge_after(m_cur);
      end else if (model_on && (m_cur > busy_end) && (req_v[0] || req_v[1])) begin
         if (req_v[0] && req_v[1]) rr_last = 1 - rr_last;
         else                      rr_last = req_v[1] ? 1 : 0;
         schedule(m_cur, rr_last);
      end
      cyc = cyc + 1;
   end

   // ---------------- per-cycle compare ----------------
   cyc_exp_t cmp_e;
   always @(negedge clk) begin
      if (model_on) begin
         cmp_e = exp_tab.exists(cyc) ? exp_tab[cyc] : blank();
         check("ack0", 32'(ack0), 32'(cmp_e.ack == 0));
         check("ack1", 32'(ack1), 32'(cmp_e.ack == 1));
         check("ram_enable", 32'(ram_enable), 32'(cmp_e.en));
         check("ram_write_en", 32'(ram_write_en), 32'(cmp_e.wr));
         if (cmp_e.en) check("ram_addr", 32'(ram_addr), 32'(cmp_e.addr));
         if (cmp_e.wr) check("ram_data_in", 32'(ram_data_in), 32'(cmp_e.wd));
         if (cmp_e.rd) check("rdata", 32'(rdata), 32'(cmp_e.rword));
      end
   end

   // ---------------- driver tasks (called #1 after a rising edge) ----------------
   task automatic raise(input int p, input logic w, input logic [AS-1:0] a, input logic [WS-1:0] d);
      we_v[p] = w; addr_v[p] = a; wdata_v[p] = d; req_v[p] = 1'b1;
   endtask

   task automatic wait_ack(input int p, output int got, output logic [WS-1:0] rd);
      bit seen = 0;
      got = -1; rd = '0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if ((p == 0) ? ack0 : ack1) begin
            seen = 1; got = cyc; rd = rdata;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL ack_timeout: port %0d got no ack, required one within 100 cycles", p);
      end
   endtask

   task automatic drop(input int p);
      @(posedge clk); #1;
      req_v[p] = 1'b0;
   endtask

   task automatic access(input int p, input logic w, input logic [AS-1:0] a, input logic [WS-1:0] d,
                         output int lat, output logic [WS-1:0] rd);
      int start, got;
      start = cyc;
      raise(p, w, a, d);
      wait_ack(p, got, rd);
      lat = got - start;
      drop(p);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   int          l0, l1, a1, a2, c0, got;
   logic [15:0] r0, r1;
   logic [7:0]  pre63, pre64, pre65;

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
      end
      for (int i = 0; i < 128; i++) begin
         ram_mem[i] = 8'($urandom_range(0, 255));
         ref_mem[i] = ram_mem[i];
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_ack0", 32'(ack0), 0);
      check("rst_ack1", 32'(ack1), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_state", 32'(dbg_state), 0);
      reset = 1'b1;

      // write then read back through the other port
      access(0, 1'b1, 7'h10, 16'hBEEF, l0, r0);
      check("t1_wr_latency", l0, 3);
      check("t1_ram10", 32'(ram_mem[7'h10]), 32'h EF);
      check("t1_ram11", 32'(ram_mem[7'h11]), 32'h BE);
      access(1, 1'b0, 7'h10, 16'h0000, l1, r1);
      check("t1_rd_latency", l1, 5);
      check("t1_rdata", 32'(r1), 32'h BEEF);

      // simultaneous requests: port 0 wins right after reset
      pulse_reset();
      fork
         access(0, 1'b1, 7'h30, 16'h1111, l0, r0);
         access(1, 1'b1, 7'h32, 16'h2222, l1, r1);
      join
      check("t2_p0_first", l0, 3);
      check("t2_p1_second", l1, 7);
      access(0, 1'b0, 7'h30, 16'h0000, l0, r0);
      check("t2_readback", 32'(r0), 32'h 1111);
      fork
         access(0, 1'b1, 7'h40, 16'h3333, l0, r0);
         access(1, 1'b1, 7'h42, 16'h4444, l1, r1);
      join
      check("t2_p1_first", l1, 3);
      check("t2_p0_second", l0, 7);

      // address wrap
      access(0, 1'b1, 7'h7F, 16'h1234, l0, r0);
      check("t3_ram7f", 32'(ram_mem[7'h7F]), 32'h 34);
      check("t3_ram00", 32'(ram_mem[7'h00]), 32'h 12);
      access(1, 1'b0, 7'h7F, 16'h0000, l1, r1);
      check("t3_rdata", 32'(r1), 32'h 1234);

      // smaller RAM: out-of-range bytes read zero, writes dropped
      ram_size = 100;
      pre63 = ram_mem[7'h63]; pre64 = ram_mem[7'h64]; pre65 = ram_mem[7'h65];
      access(0, 1'b0, 7'h63, 16'h0000, l0, r0);
      check("t4_rd_hi", 32'(r0[15:8]), 0);
      check("t4_rd_lo", 32'(r0[7:0]), 32'(pre63));
      access(1, 1'b1, 7'h64, 16'hA5A5, l1, r1);
      check("t4_ram64_kept", 32'(ram_mem[7'h64]), 32'(pre64));
      check("t4_ram65_kept", 32'(ram_mem[7'h65]), 32'(pre65));
      ram_size = 128;

      // request held through ack: second access after one IDLE cycle
      raise(0, 1'b1, 7'h50, 16'hCAFE);
      wait_ack(0, a1, r0);
      wait_ack(0, a2, r0);
      drop(0);
      check("t6_b2b_gap", a2 - a1, 4);
      check("t6_ram50", 32'(ram_mem[7'h50]), 32'h FE);

      // reset during the first capture cycle of a port-1 read
      raise(1, 1'b0, 7'h10, 16'h0000);
      c0 = cyc;
      @(posedge clk); #1;
      raise(0, 1'b1, 7'h20, 16'h5A5A);
      @(posedge clk); #1;
      reset = 1'b0;
      req_v[1] = 1'b0;
      @(posedge clk); #1;
      check("t5_ack0", 32'(ack0), 0);
      check("t5_ack1", 32'(ack1), 0);
      check("t5_enable", 32'(ram_enable), 0);
      check("t5_write_en", 32'(ram_write_en), 0);
      check("t5_ram_addr", 32'(ram_addr), 0);
      check("t5_data_in", 32'(ram_data_in), 0);
      check("t5_rdata", 32'(rdata), 0);
      check("t5_state", 32'(dbg_state), 0);
      reset = 1'b1;
      wait_ack(0, got, r0);
      drop(0);
      check("t5_p0_latency", got - (c0 + 3), 3);
      check("t5_ram20", 32'(ram_mem[7'h20]), 32'h 5A);

      // random traffic from both ports, checked cycle by cycle by the model
      fork
         begin
            int          lr;
            logic [15:0] rr;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               access(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                      16'($urandom_range(0, 65535)), lr, rr);
            end
         end
         begin
            int          lr;
            logic [15:0] rr;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               access(1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                      16'($urandom_range(0, 65535)), lr, rr);
            end
         end
      join

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout: bench still running at %0t, required completion earlier", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
